mmu_bus_ctrl: RTL
=================

MMU_BUS_CTRL -- requirements
Module: mmu_bus_ctrl

Interface
REQ-001 SHALL have parameter HRAM_BASE, default 16'hFF80, the first address of the internal high-RAM window, which ends at 16'hFFFE.
REQ-002 SHALL have parameter HRAM_DEPTH, default 127, the number of high-RAM bytes.
REQ-003 clk  in  1  clock; all logic SHALL be sampled on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req_op  in  bus_op_t  CPU request: BUS_OP_IDLE, BUS_OP_READ or BUS_OP_WRITE.
REQ-006 req_size  in  bus_size_t  BUS_SIZE_BYTE or BUS_SIZE_WORD.
REQ-007 req_addr  in  16  byte address.
REQ-008 req_wdata  in  16  write data; [7:0] is the low or only byte.
REQ-009 resp_done  out  1  one-cycle completion pulse.
REQ-010 resp_rdata  out  16  read result, valid while resp_done=1.
REQ-011 mem_req  out  1  backend byte-transfer request.
REQ-012 mem_we  out  1  backend write enable, qualified by mem_req.
REQ-013 mem_addr  out  16  backend byte address.
REQ-014 mem_wdata  out  8  backend write byte.
REQ-015 mem_ack  in  1  backend completion of the current byte; mem_rdata is valid in the same cycle.
REQ-016 mem_rdata  in  8  backend read byte.

Function
REQ-017 The FSM SHALL have the states IDLE, XFER_LO, XFER_HI and DONE.
REQ-018 In IDLE, a req_op other than BUS_OP_IDLE SHALL latch op, size, addr and wdata, and the FSM SHALL move to XFER_LO on the next cycle; the CPU SHALL NOT be required to hold the inputs afterwards.
REQ-019 XFER_LO SHALL transfer the byte at the latched addr. XFER_HI SHALL transfer the byte at addr+1, computed modulo 2^16 so that 16'hFFFF wraps to 16'h0000.
REQ-020 For a byte access, XFER_LO SHALL go directly to DONE. For a word access, XFER_LO SHALL go to XFER_HI, and XFER_HI SHALL go to DONE.
REQ-021 Backend transfers: mem_req SHALL be held high with stable mem_addr, mem_we and mem_wdata until the cycle in which mem_ack=1. mem_req SHALL drop in the following cycle. mem_ack received while mem_req=0 SHALL be ignored.
REQ-022 Word writes SHALL be little-endian: wdata[7:0] goes to addr and wdata[15:8] goes to addr+1.
REQ-023 Byte reads SHALL return {8'h00, byte}. Word reads SHALL return {byte@addr+1, byte@addr}.
REQ-024 In DONE, resp_done SHALL be 1 for exactly one cycle and resp_rdata SHALL hold the assembled value; writes SHALL return 16'h0000. The FSM SHALL then return to IDLE.
REQ-025 A req_op still non-IDLE in the cycle after DONE SHALL start a new transaction; back-to-back requests SHALL need no idle cycle.
REQ-026 Minimum latency from acceptance to resp_done SHALL be: byte 3 cycles and word 4 cycles when mem_ack is asserted immediately.
REQ-027 req_op changes while the FSM is not in IDLE SHALL be ignored.
REQ-028 resp_rdata SHALL hold its last value outside DONE.

Reset
REQ-029 reset SHALL force the FSM to IDLE and set resp_done=0, resp_rdata=16'h0000, mem_req=0, mem_we=0, mem_addr=16'h0000 and mem_wdata=8'h00.
REQ-030 A reset during a transaction SHALL abandon it without asserting resp_done; a pending mem_ack SHALL be ignored.
REQ-031 High-RAM contents SHALL NOT be cleared by reset.

Configuration
REQ-032 With MMU_HRAM_EN defined, byte addresses in [HRAM_BASE, 16'hFFFE] SHALL be served from internal storage in one cycle per byte, with no mem_req; these accesses SHALL complete as if mem_ack had been asserted immediately.
REQ-033 Without MMU_HRAM_EN, every address SHALL be forwarded to the backend and no internal storage SHALL exist.
REQ-034 Each byte of a word access SHALL be routed independently; for example, a word at 16'hFFFE goes to high RAM for the low byte and to the backend at 16'hFFFF for the high byte.

Verification
REQ-035 Byte read at 16'h0100 with mem_rdata=8'h3E and immediate ack -> one backend transfer; resp_done 3 cycles after acceptance with resp_rdata=16'h003E.
REQ-036 Word write of 16'hBEEF at 16'hC000 -> backend writes 8'hEF at C000, then 8'hBE at C001; single resp_done.
REQ-037 Word read at 16'hFFFF -> backend addresses FFFF, then 0000; bytes 8'h12, 8'h34 yield resp_rdata=16'h3412.
REQ-038 Backend ack delayed by 5 cycles -> mem_req and mem_addr held stable for the full wait; resp_done not asserted early.
REQ-039 With MMU_HRAM_EN: byte write 8'h5A to FF80, then a byte read from FF80 -> mem_req stays 0 throughout; read returns 16'h005A.
REQ-040 reset asserted in XFER_HI of a word read -> next cycle shows FSM in IDLE, mem_req=0 and no resp_done; a following byte read completes normally.

Source files
------------

// File: rtl/mmu_bus_pkg.sv
// Bus request types shared by the MMU bus controller and its users.
package mmu_bus_pkg;

  typedef enum logic [1:0] {
    BUS_OP_IDLE  = 2'd0,
    BUS_OP_READ  = 2'd1,
    BUS_OP_WRITE = 2'd2
  } bus_op_t;

  typedef enum logic {
    BUS_SIZE_BYTE = 1'b0,
    BUS_SIZE_WORD = 1'b1
  } bus_size_t;

endpackage

// File: rtl/mmu_bus_ctrl.sv
// CPU-to-byte-bus controller: splits byte/word requests into byte transfers.
// Define MMU_HRAM_EN to serve [HRAM_BASE, 16'hFFFE] from internal high RAM.
module mmu_bus_ctrl
  import mmu_bus_pkg::*;
#(
  parameter logic [15:0] HRAM_BASE  = 16'hFF80,
  parameter int unsigned HRAM_DEPTH = 127
) (
  input  logic        clk,
  input  logic        reset,
  input  bus_op_t     req_op,
  input  bus_size_t   req_size,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_done,
  output logic [15:0] resp_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata
);

`ifdef MMU_HRAM_EN
  localparam logic HRAM_ON = 1'b1;
`else
  localparam logic HRAM_ON = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    XFER_LO,
    XFER_HI,
    DONE
  } state_t;

  state_t      state_q;
  logic        we_q;
  logic        word_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [7:0]  lo_q;
  logic        resp_done_q;
  logic [15:0] resp_rdata_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic [15:0] mem_addr_q;
  logic [7:0]  mem_wdata_q;

  logic [15:0] hi_addr;
  logic [15:0] cur_addr;
  logic        cur_hit;
  logic        byte_ack;
  logic [7:0]  hram_rd;
  logic [7:0]  byte_rd;
  logic [15:0] fin_rdata;

  function automatic logic hram_hit(input logic [15:0] a);
    logic [15:0] off;
    off = a - HRAM_BASE;
    return HRAM_ON && (a >= HRAM_BASE) && (32'(off) < HRAM_DEPTH);
  endfunction

  // addr+1 wraps naturally in 16 bits
  assign hi_addr  = addr_q + 16'd1;
  assign cur_addr = (state_q == XFER_HI) ? hi_addr : addr_q;
  assign cur_hit  = ((state_q == XFER_LO) || (state_q == XFER_HI))
                    && hram_hit(cur_addr);
  assign byte_ack = cur_hit | (mem_req_q & mem_ack);
  assign byte_rd  = cur_hit ? hram_rd : mem_rdata;
  assign fin_rdata = we_q   ? 16'h0000 :
                     word_q ? {byte_rd, lo_q} : {8'h00, byte_rd};

`ifdef MMU_HRAM_EN
  localparam int AW = (HRAM_DEPTH > 1) ? $clog2(HRAM_DEPTH) : 1;

  logic [7:0]    hram_q [HRAM_DEPTH];
  logic [AW-1:0] hram_idx;
  logic [7:0]    cur_wbyte;

  assign hram_idx  = AW'(cur_addr - HRAM_BASE);
  assign cur_wbyte = (state_q == XFER_HI) ? wdata_q[15:8] : wdata_q[7:0];
  assign hram_rd   = hram_q[hram_idx];

  // no reset: contents survive a controller reset
  always_ff @(posedge clk) begin
    if (!reset && cur_hit && we_q) hram_q[hram_idx] <= cur_wbyte;
  end
`else
  assign hram_rd = 8'h00;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      word_q       <= 1'b0;
      addr_q       <= 16'h0000;
      wdata_q      <= 16'h0000;
      lo_q         <= 8'h00;
      resp_done_q  <= 1'b0;
      resp_rdata_q <= 16'h0000;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 16'h0000;
      mem_wdata_q  <= 8'h00;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_op != BUS_OP_IDLE) begin
            we_q        <= (req_op == BUS_OP_WRITE);
            word_q      <= (req_size == BUS_SIZE_WORD);
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            mem_req_q   <= !hram_hit(req_addr);
            mem_we_q    <= (req_op == BUS_OP_WRITE);
            mem_addr_q  <= req_addr;
            mem_wdata_q <= req_wdata[7:0];
            state_q     <= XFER_LO;
          end
        end
        XFER_LO: begin
          if (byte_ack) begin
            lo_q <= byte_rd;
            if (word_q) begin
              mem_req_q   <= !hram_hit(hi_addr);
              mem_addr_q  <= hi_addr;
              mem_wdata_q <= wdata_q[15:8];
              state_q     <= XFER_HI;
            end else begin
              mem_req_q    <= 1'b0;
              mem_we_q     <= 1'b0;
              resp_done_q  <= 1'b1;
              resp_rdata_q <= fin_rdata;
              state_q      <= DONE;
            end
          end
        end
        XFER_HI: begin
          if (byte_ack) begin
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            resp_done_q  <= 1'b1;
            resp_rdata_q <= fin_rdata;
            state_q      <= DONE;
          end
        end
        DONE: begin
          resp_done_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign resp_done  = resp_done_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule
